// File: rtl/mips_dmem_responder.sv
// Word-addressed data memory for the MIPS core's data-access port. It has valid/ready
// request and response channels, programmable wait states, byte-enabled stores and error flagging.
module mips_dmem_responder #(
  parameter int AW_WORDS    = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << AW_WORDS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [31:0]         mem [DEPTH];
  logic                lat_wr;
  logic                lat_err;
  logic [AW_WORDS-1:0] lat_idx;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_be;
  logic [3:0]          cnt;
  logic                accept;
  logic                commit;
  logic                req_err;
  logic                mem_we;

  // Misaligned byte address, or any address bit above the implemented word range.
  assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW_WORDS + 2)) != 32'd0);

  // A write is blocked while reset is asserted, so an uncommitted store is dropped.
  assign mem_we = commit && rst && lat_wr && !lat_err;

  // NOTE: every signal gets a default before the case statement, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The memory access takes one cycle beyond the programmed wait states, so the
  // counter starts at WAIT_CYCLES and RESP is entered on the edge after it reaches zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept)                           cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;

      if (commit) begin
        rsp_err   <= lat_err;
        rsp_rdata <= (lat_wr || lat_err) ? 32'd0 : mem[lat_idx];
      end else if (rsp_valid && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // NOTE: the request payload and the memory array are left out of reset on purpose.
  // The payload is only consumed after an acceptance, and the memory contents must survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_wr    <= req_wr;
      lat_err   <= req_err;
      lat_idx   <= req_addr[AW_WORDS+1:2];
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder. It drives directed and randomized load/store
// traffic against a word-array reference model. A second instance covers the zero-wait configuration.
module tb_mips_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_wr;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  mips_dmem_responder #(.AW_WORDS(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mips_dmem_responder #(.AW_WORDS(10), .WAIT_CYCLES(0)) dut_zero (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wr(z_req_wr),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  // Reference model: the error rule, then the word-array effect of one request.
  function automatic bit model_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'd4096);
  endfunction

  function automatic logic [31:0] model_access(input logic wr, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] be);
    if (model_err(addr)) return 32'd0;
    if (!wr) return ref_mem[addr / 4];
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[addr / 4][8*i +: 8] = wdata[8*i +: 8];
    return 32'd0;
  endfunction

  // Present a request for one acceptance edge. With noise set, req_valid stays high while
  // junk stores are driven; the DUT must ignore them outside IDLE.
  task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit noise);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = noise; req_wr = 1'b1; req_be = 4'hF; req_wdata = $urandom;
    req_addr  = 32'h100 + 4 * $urandom_range(0, 15);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d edges, required 1", rsp_valid, lat);
    end
  endtask

  task automatic ack_rsp();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat);
    send_req(wr, addr, wdata, be, 1'b1);
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    ack_rsp();
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_wr = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 32'd0}) begin
      errors++;
      $display("FAIL reset_hold: ready/valid/err=%b%b%b rdata=%h, required 100 and 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: ready/valid/err=%b%b%b, required 100", req_ready, rsp_valid, rsp_err);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; logic [31:0] exp;
    exp = model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== exp) begin
      errors++;
      $display("FAIL store_word: lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=%h", lat, er, rd, exp);
    end
    exp = model_access(1'b0, 32'h10, 32'h0, 4'h0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || exp !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL load_word: lat=%0d err=%b rdata=%h, required lat=3 err=0 rdata=deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic er; int lat;
    void'(model_access(1'b1, 32'h20, 32'h11223344, 4'hF));
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    void'(model_access(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101));
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    void'(model_access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000));
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL store_be0: err=%b rdata=%h, required err=0 rdata=0", er, rd);
    end
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_merge: rdata=%h, required 11bb33dd", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    void'(model_access(1'b1, 32'h0, 32'hCAFEF00D, 4'hF));
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    xact(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL misaligned_load: err=%b rdata=%h, required err=1 rdata=0", er, rd);
    end
    xact(1'b1, 32'h00001000, 32'h55555555, 4'hF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL range_store: err=%b rdata=%h, required err=1 rdata=0", er, rd);
    end
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL range_no_alias: err=%b rdata=%h, required err=0 rdata=cafef00d", er, rd);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== ref_mem[4] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b ready=%b err=%b rdata=%h, required 1 0 0 %h",
                 i, rsp_valid, req_ready, rsp_err, rsp_rdata, ref_mem[4]);
      end
    end
    ack_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b rdata=%h, required 0 1 0", rsp_valid, req_ready, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    void'(model_access(1'b1, 32'h40, 32'h0BADF00D, 4'hF));
    xact(1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, er, lat);
    send_req(1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stale: valid=%b, required 0", rsp_valid);
    end
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    checks++;
    if (rd !== ref_mem[16]) begin
      errors++;
      $display("FAIL reset_mid_nowrite: rdata=%h, required %h", rd, ref_mem[16]);
    end
  endtask

  task automatic test_zero_wait();
    int lat;
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      z_req_valid = 1'b1; z_req_wr = (op == 0); z_req_addr = 32'h8;
      z_req_wdata = 32'h5A5A1234; z_req_be = 4'hF;
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      lat = 0;
      while (!z_rsp_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 1 || z_rsp_err !== 1'b0 || z_rsp_rdata !== ((op == 0) ? 32'd0 : 32'h5A5A1234)) begin
        errors++;
        $display("FAIL zero_wait[%0d]: lat=%0d err=%b rdata=%h, required lat=1 err=0", op, lat, z_rsp_err, z_rsp_rdata);
      end
      @(negedge clk); z_rsp_ready = 1'b1;
      @(posedge clk); #1;
      z_rsp_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp, addr, wdata; logic er, wr; logic [3:0] be; int lat, sel;
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom;
      void'(model_access(1'b1, 32'h100 + 4 * w, wdata, 4'hF));
      xact(1'b1, 32'h100 + 4 * w, wdata, 4'hF, rd, er, lat);
    end
    for (int n = 0; n < 40; n++) begin
      addr  = 32'h100 + 4 * $urandom_range(0, 15);
      sel   = $urandom_range(0, 7);
      if (sel == 0) addr = addr + $urandom_range(1, 3);
      if (sel == 1) addr = addr | (32'd1 << $urandom_range(12, 31));
      wr    = $urandom_range(0, 1);
      wdata = $urandom;
      be    = $urandom;
      exp   = model_access(wr, addr, wdata, be);
      xact(wr, addr, wdata, be, rd, er, lat);
      checks++;
      if (rd !== exp || er !== model_err(addr) || lat !== 3) begin
        errors++;
        $display("FAIL random[%0d] wr=%b addr=%h be=%h: rdata=%h err=%b lat=%0d, required %h %b 3",
                 n, wr, addr, be, rd, er, lat, exp, model_err(addr));
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
